// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART host-side bus sequencer: access opcodes,
// sequencer/cycle phase encodings and the default core register map.
package uart_bus_pkg;

  typedef enum logic [1:0] {
    OP_STAT = 2'd0,
    OP_RXRD = 2'd1,
    OP_TXWR = 2'd2
  } op_e;

  // Bus cycle phases, owned by the cycle generator
  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_STROBE = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  // Scheduler states, owned by the top; ACCESS spans SETUP and STROBE
  localparam logic [1:0] SCH_IDLE   = 2'd0;
  localparam logic [1:0] SCH_ACCESS = 2'd1;
  localparam logic [1:0] SCH_HOLD   = 2'd2;
  localparam logic [1:0] SCH_DECIDE = 2'd3;

  localparam logic [3:0] DEF_ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] DEF_ADDR_RXDATA  = 4'h1;
  localparam logic [3:0] DEF_ADDR_STATUS  = 4'h2;
  localparam int         DEF_RX_EMPTY_BIT = 0;
  localparam int         DEF_TX_FULL_BIT  = 1;

  function automatic logic [3:0] op_addr(input op_e op, input logic [3:0] a_tx,
                                         input logic [3:0] a_rx, input logic [3:0] a_st);
    case (op)
      OP_RXRD: op_addr = a_rx;
      OP_TXWR: op_addr = a_tx;
      default: op_addr = a_st;
    endcase
  endfunction

endpackage

// File: rtl/uart_bus_cycle_gen.sv
// Generates one chip-select/strobe access: SETUP, STROBE_CYC strobe cycles, HOLD.
// All bus pins are registered; done marks the last strobe cycle, when rdata is valid.
module uart_bus_cycle_gen import uart_bus_pkg::*; #(
  parameter int STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  op_e        op,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [3:0] bus_addr,
  output logic       n_cs,
  output logic       n_rd,
  output logic       n_we,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata
);

  localparam logic [3:0] LAST = 4'(STROBE_CYC - 1);

  logic [1:0] phase, phase_nxt;
  logic [3:0] cnt, cnt_nxt;
  op_e        op_q;

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    case (phase)
      PH_IDLE:   if (start) phase_nxt = PH_SETUP;
      PH_SETUP: begin
        phase_nxt = PH_STROBE;
        cnt_nxt   = 4'd0;
      end
      PH_STROBE: begin
        if (cnt == LAST) phase_nxt = PH_HOLD;
        else             cnt_nxt   = cnt + 4'd1;
      end
      PH_HOLD:   phase_nxt = PH_IDLE;
      default:   phase_nxt = PH_IDLE;
    endcase
  end

  assign done  = (phase == PH_STROBE) && (cnt == LAST);
  assign rdata = bus_rdata;

  // Pins are computed from the next phase so they change exactly on phase entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= PH_IDLE;
      cnt       <= 4'd0;
      op_q      <= OP_STAT;
      bus_addr  <= 4'h0;
      bus_wdata <= 8'h00;
      n_cs      <= 1'b1;
      n_rd      <= 1'b1;
      n_we      <= 1'b1;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      if (phase == PH_IDLE && start) begin
        op_q      <= op;
        bus_addr  <= addr;
        bus_wdata <= (op == OP_TXWR) ? wdata : 8'h00;
      end
      n_cs <= (phase_nxt == PH_IDLE);
      n_rd <= !((phase_nxt == PH_STROBE) && (op_q != OP_TXWR));
      n_we <= !((phase_nxt == PH_STROBE) && (op_q == OP_TXWR));
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Host-side sequencer for the UART core bus: polls status, drains RX bytes and
// pushes TX bytes as timed chip-select cycles, with valid/ready byte streams.
module uart_bus_master import uart_bus_pkg::*; #(
  parameter int         STROBE_CYC   = 2,
  parameter int         POLL_CYC     = 1000,
  parameter logic [3:0] ADDR_TXDATA  = DEF_ADDR_TXDATA,
  parameter logic [3:0] ADDR_RXDATA  = DEF_ADDR_RXDATA,
  parameter logic [3:0] ADDR_STATUS  = DEF_ADDR_STATUS,
  parameter int         RX_EMPTY_BIT = DEF_RX_EMPTY_BIT,
  parameter int         TX_FULL_BIT  = DEF_TX_FULL_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  input  logic       p_IrqSig_i,
  output logic [7:0] status_o,
  output logic       busy_o
);

  logic [1:0]  state, state_nxt;
  op_e         cur_op, start_op;
  logic        start, done, poll_hit;
  logic [3:0]  start_addr;
  logic [7:0]  rdata;
  logic [15:0] poll_cnt;

  assign poll_hit   = (poll_cnt == 16'(POLL_CYC - 1));
  assign start_addr = op_addr(start_op, ADDR_TXDATA, ADDR_RXDATA, ADDR_STATUS);

  // Every data access is bracketed by status reads; RX wins over TX so the core never overruns
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    start_op  = OP_STAT;
    case (state)
      SCH_IDLE:   start = p_IrqSig_i || tx_valid_i || poll_hit;
      SCH_ACCESS: if (done) state_nxt = SCH_HOLD;
      SCH_HOLD:   state_nxt = SCH_DECIDE;
      SCH_DECIDE: begin
        state_nxt = SCH_IDLE;
        if (cur_op != OP_STAT) begin
          start = 1'b1;
        end else if (!status_o[RX_EMPTY_BIT] && !rx_valid_o) begin
          start    = 1'b1;
          start_op = OP_RXRD;
        end else if (tx_valid_i && !status_o[TX_FULL_BIT]) begin
          start    = 1'b1;
          start_op = OP_TXWR;
        end
      end
      default:    state_nxt = SCH_IDLE;
    endcase
    if (start) state_nxt = SCH_ACCESS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCH_IDLE;
      cur_op     <= OP_STAT;
      poll_cnt   <= 16'd0;
      tx_ready_o <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= 8'h00;
      status_o   <= 8'hFF;
      busy_o     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt == SCH_ACCESS) || (state_nxt == SCH_HOLD);
      if (start) cur_op <= start_op;

      if (state == SCH_IDLE && !start) poll_cnt <= poll_cnt + 16'd1;
      else                             poll_cnt <= 16'd0;

      // Results land on the edge that ends the strobe, i.e. visible during HOLD
      tx_ready_o <= done && (cur_op == OP_TXWR);
      if (done && cur_op == OP_STAT) status_o <= rdata;

      if (done && cur_op == OP_RXRD) begin
        rx_data_o  <= rdata;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  uart_bus_cycle_gen #(
    .STROBE_CYC (STROBE_CYC)
  ) u_cycle_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (start_op),
    .addr      (start_addr),
    .wdata     (tx_data_i),
    .done      (done),
    .rdata     (rdata),
    .bus_addr  (AddrBus_o),
    .n_cs      (n_ChipSelect_o),
    .n_rd      (n_rd_o),
    .n_we      (n_we_o),
    .bus_wdata (DataBus_o),
    .bus_rdata (DataBus_i)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a small UART core register model
// and a bus monitor that logs each completed access.
`timescale 1ns/1ps
module tb_uart_bus_master;

  localparam int S    = 2;
  localparam int POLL = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [3:0] AddrBus_o;
  logic       n_ChipSelect_o;
  logic       n_rd_o;
  logic       n_we_o;
  logic [7:0] DataBus_o;
  logic [7:0] DataBus_i;
  logic       p_IrqSig_i;
  logic [7:0] status_o;
  logic       busy_o;

  always #12.5 clk = ~clk;

  uart_bus_master #(
    .STROBE_CYC (S),
    .POLL_CYC   (POLL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_data_i      (tx_data_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .AddrBus_o      (AddrBus_o),
    .n_ChipSelect_o (n_ChipSelect_o),
    .n_rd_o         (n_rd_o),
    .n_we_o         (n_we_o),
    .DataBus_o      (DataBus_o),
    .DataBus_i      (DataBus_i),
    .p_IrqSig_i     (p_IrqSig_i),
    .status_o       (status_o),
    .busy_o         (busy_o)
  );

  // Core model: status = {tx_full, rx_empty}, RX FIFO popped when a read of addr 1 completes
  logic [7:0] rx_mem [0:7];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic       tx_full = 1'b0;
  logic [7:0] core_status;
  assign core_status = {6'b0, tx_full, (rx_wr == rx_rd)};
  assign DataBus_i = n_ChipSelect_o       ? 8'h00 :
                     (AddrBus_o == 4'h2)  ? core_status :
                     (AddrBus_o == 4'h1)  ? rx_mem[rx_rd[2:0]] : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       log_we   [0:255];
  logic [3:0] log_addr [0:255];
  logic [7:0] log_data [0:255];
  int         log_slen [0:255];
  int         log_cyc  [0:255];
  int         acc_n = 0, slen = 0, setup_cyc = 0;
  int         txr_cnt = 0, txr_cyc = 0, rx_got_n = 0;
  logic [7:0] rx_got [0:15];
  logic       cs_prev = 1'b1, cur_we = 1'b0, logged = 1'b0;
  logic [3:0] cur_addr = 4'h0;
  logic [7:0] cur_data = 8'h00;

  always begin
    @(negedge clk);
    #1;
    if (!n_ChipSelect_o) begin
      if (cs_prev) begin
        setup_cyc = cyc;
        slen      = 0;
        logged    = 1'b0;
      end
      if (!n_rd_o || !n_we_o) begin
        slen++;
        cur_we   = !n_we_o;
        cur_addr = AddrBus_o;
        cur_data = !n_we_o ? DataBus_o : DataBus_i;
      end else if (slen > 0 && !logged && acc_n < 256) begin
        log_we[acc_n]   = cur_we;
        log_addr[acc_n] = cur_addr;
        log_data[acc_n] = cur_data;
        log_slen[acc_n] = slen;
        log_cyc[acc_n]  = setup_cyc;
        acc_n++;
        logged = 1'b1;
        if (!cur_we && cur_addr == 4'h1) rx_rd++;
      end
    end
    cs_prev = n_ChipSelect_o;
    if (tx_ready_o) begin
      txr_cnt++;
      txr_cyc = cyc;
    end
    if (rx_valid_o && rx_ready_i && rx_got_n < 16) begin
      rx_got[rx_got_n] = rx_data_o;
      rx_got_n++;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (acc_n < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(acc_n >= n), 32'd1);
  endtask

  task automatic tx_send(input logic [7:0] d, input int budget, output logic ok);
    ok         = 1'b0;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (tx_ready_o) ok = 1'b1;
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] d);
    rx_mem[rx_wr[2:0]] = d;
    rx_wr++;
  endtask

  initial begin
    int   base, base2, t0, cs_low, nw, nr, nrx;
    logic ok, seen;

    rst = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'h00; rx_ready_i = 1'b0; p_IrqSig_i = 1'b0;

    // Reset values, then a quiet poll interval
    tick(3);
    chk("rst_ncs", n_ChipSelect_o, 1);
    chk("rst_nrd", n_rd_o, 1);
    chk("rst_nwe", n_we_o, 1);
    chk("rst_status", status_o, 8'hFF);
    chk("rst_rxvalid", rx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_txready", tx_ready_o, 0);
    chk("rst_addr", AddrBus_o, 0);
    rst = 1'b1;
    cs_low = 0;
    for (int i = 0; i < POLL - 1; i++) begin
      @(negedge clk);
      if (!n_ChipSelect_o) cs_low++;
    end
    chk("poll_quiet_cs", cs_low, 0);
    chk("poll_quiet_acc", acc_n, 0);
    wait_acc(1, 20, "poll_timeout");
    chk("poll_addr", log_addr[0], 4'h2);
    chk("poll_we", log_we[0], 0);
    chk("poll_slen", log_slen[0], S);
    chk("poll_status", status_o, 8'h01);

    // TX write with room in the core
    tick(5);
    base = acc_n; t0 = txr_cnt;
    tx_send(8'hA5, 50, ok);
    chk("tx_ack", ok, 1);
    tick(10);
    chk("tx_nacc", acc_n - base, 3);
    chk("tx_stat_addr", log_addr[base], 4'h2);
    chk("tx_stat_we", log_we[base], 0);
    chk("tx_wr_addr", log_addr[base + 1], 4'h0);
    chk("tx_wr_we", log_we[base + 1], 1);
    chk("tx_wr_data", log_data[base + 1], 8'hA5);
    chk("tx_wr_slen", log_slen[base + 1], S);
    chk("tx_restat_addr", log_addr[base + 2], 4'h2);
    chk("tx_pulses", txr_cnt - t0, 1);
    chk("tx_ready_lat", txr_cyc - log_cyc[base + 1], S + 1);
    chk("tx_stat_to_wr", log_cyc[base + 1] - log_cyc[base], S + 3);

    // TX full: only status reads until the core has room
    tx_full = 1'b1;
    base = acc_n; t0 = txr_cnt;
    tx_data_i = 8'h3C; tx_valid_i = 1'b1;
    tick(40);
    nw = 0; nr = 0;
    for (int i = base; i < acc_n; i++) begin
      if (log_we[i]) nw++;
      else if (log_addr[i] == 4'h2) nr++;
    end
    chk("full_nowrite", nw, 0);
    chk("full_polls", 32'(nr >= 5), 1);
    chk("full_status", status_o, 8'h03);
    chk("full_noready", txr_cnt - t0, 0);
    tx_full = 1'b0;
    tx_send(8'h3C, 40, ok);
    chk("full_ack", ok, 1);
    tick(10);
    nw = 0;
    for (int i = base; i < acc_n; i++) begin
      if (log_we[i]) begin
        nw++;
        chk("full_wr_data", log_data[i], 8'h3C);
      end
    end
    chk("full_nwrites", nw, 1);

    // IRQ drain of two bytes with a ready consumer
    push_rx(8'h11); push_rx(8'h22);
    rx_ready_i = 1'b1;
    base = acc_n;
    p_IrqSig_i = 1'b1;
    wait_acc(base + 6, 100, "drain_timeout");
    p_IrqSig_i = 1'b0;
    tick(10);
    chk("drain_a0", log_addr[base], 4'h2);
    chk("drain_a1", log_addr[base + 1], 4'h1);
    chk("drain_d1", log_data[base + 1], 8'h11);
    chk("drain_a2", log_addr[base + 2], 4'h2);
    chk("drain_a3", log_addr[base + 3], 4'h1);
    chk("drain_d3", log_data[base + 3], 8'h22);
    chk("drain_a4", log_addr[base + 4], 4'h2);
    chk("drain_empty", log_data[base + 4], 8'h01);
    chk("drain_gap_direct", log_cyc[base + 1] - log_cyc[base], S + 3);
    chk("drain_gap_irqloop", log_cyc[base + 5] - log_cyc[base + 4], S + 4);
    chk("drain_nrx", rx_got_n, 2);
    chk("drain_rx0", rx_got[0], 8'h11);
    chk("drain_rx1", rx_got[1], 8'h22);

    // Backpressure: one RX read held, RX priority over a simultaneous TX byte
    rx_ready_i = 1'b0;
    push_rx(8'h33); push_rx(8'h44);
    base = acc_n;
    tx_send(8'h5A, 80, ok);
    chk("bp_tx_ack", ok, 1);
    tick(10);
    chk("bp_nacc", acc_n - base, 5);
    chk("bp_a0", log_addr[base], 4'h2);
    chk("bp_a1", log_addr[base + 1], 4'h1);
    chk("bp_d1", log_data[base + 1], 8'h33);
    chk("bp_a2", log_addr[base + 2], 4'h2);
    chk("bp_a3_we", log_we[base + 3], 1);
    chk("bp_d3", log_data[base + 3], 8'h5A);
    chk("bp_a4", log_addr[base + 4], 4'h2);
    nrx = 0;
    for (int i = base; i < acc_n; i++) if (!log_we[i] && log_addr[i] == 4'h1) nrx++;
    chk("bp_one_rxrd", nrx, 1);
    chk("bp_rxvalid", rx_valid_o, 1);
    chk("bp_rxdata", rx_data_o, 8'h33);
    rx_ready_i = 1'b1;
    p_IrqSig_i = 1'b1;
    for (int i = 0; i < 60 && rx_got_n < 4; i++) @(negedge clk);
    p_IrqSig_i = 1'b0;
    chk("bp_nrx", rx_got_n, 4);
    chk("bp_rx2", rx_got[2], 8'h33);
    chk("bp_rx3", rx_got[3], 8'h44);
    tick(10);

    // Reset during the write strobe
    base = acc_n; t0 = txr_cnt;
    tx_data_i = 8'h77; tx_valid_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (!n_we_o) seen = 1'b1;
    end
    chk("mid_we_seen", seen, 1);
    rst = 1'b0;
    #1;
    chk("mid_nwe", n_we_o, 1);
    chk("mid_ncs", n_ChipSelect_o, 1);
    chk("mid_nrd", n_rd_o, 1);
    chk("mid_txready", tx_ready_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_status", status_o, 8'hFF);
    tick(2);
    rst = 1'b1;
    base2 = acc_n;
    nw = 0;
    for (int i = base; i < base2; i++) if (log_we[i]) nw++;
    chk("mid_no_partial", nw, 0);
    chk("mid_no_pulse", txr_cnt - t0, 0);
    tx_send(8'h77, 40, ok);
    chk("mid_ack", ok, 1);
    tick(10);
    chk("mid_restart_addr", log_addr[base2], 4'h2);
    chk("mid_restart_we", log_we[base2], 0);
    chk("mid_wr_we", log_we[base2 + 1], 1);
    chk("mid_wr_data", log_data[base2 + 1], 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
